// File: rtl/calc_pkg.sv
// Shared constants for the matrix-calculator datapath: arbiter states,
// packed matrix address field widths and requester IDs.
package calc_pkg;

    localparam logic [0:0] ARB_FREE   = 1'b0;
    localparam logic [0:0] ARB_LOCKED = 1'b1;

    localparam int SLOT_W = 2;
    localparam int ROW_W  = 3;
    localparam int COL_W  = 3;

    localparam int REQ_CONV  = 0;
    localparam int REQ_MATOP = 1;
    localparam int REQ_DISP  = 2;

endpackage

// File: rtl/mat_rd_arbiter_if.sv
// Requester-side and memory-side signals of the shared matrix read port.
// The arbiter takes the slave view; requesters plus memory take the master view.
interface mat_rd_arbiter_if
    import calc_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int DW    = 16,
    parameter int AW    = 8
) ();

    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    lock;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    rsp_valid;
    logic [DW-1:0]       rsp_data;
    logic [SLOT_W-1:0]   mem_rd_slot;
    logic [ROW_W-1:0]    mem_rd_row;
    logic [COL_W-1:0]    mem_rd_col;
    logic [DW-1:0]       mem_rd_data;
    logic                lock_broken;

    modport slave (
        input  req, lock, req_addr, mem_rd_data,
        output gnt, rsp_valid, rsp_data, mem_rd_slot, mem_rd_row, mem_rd_col, lock_broken
    );

    modport master (
        output req, lock, req_addr, mem_rd_data,
        input  gnt, rsp_valid, rsp_data, mem_rd_slot, mem_rd_row, mem_rd_col, lock_broken
    );

endinterface

// File: rtl/mat_rd_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first asserted request
// scanning from ptr upward, wrapping modulo N_REQ.
module rr_pick #(
    parameter  int N_REQ = 3,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IW-1:0]    win_idx,
    output logic             any
);

    int cand;

    always_comb begin
        winner  = '0;
        win_idx = '0;
        any     = 1'b0;
        cand    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!any && req[cand]) begin
                winner[cand] = 1'b1;
                win_idx      = IW'(cand);
                any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mat_rd_arbiter.sv
// Round-robin arbiter for the matrix memory read port with a bounded burst
// lock; read data returns one cycle after grant with a one-hot valid.
module mat_rd_arbiter
    import calc_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int DW       = 16,
    parameter int AW       = 8,
    parameter int MAX_LOCK = 16
) (
    input logic             clk,
    input logic             rst_n,
    mat_rd_arbiter_if.slave bus
);

    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    logic [0:0]       state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [N_REQ-1:0] rsp_valid_q;
    logic             lock_broken_q, lock_broken_d;

    logic [N_REQ-1:0] pick_onehot;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic [N_REQ-1:0] gnt_c;
    logic [IW-1:0]    win_idx;
    logic [AW-1:0]    sel_addr;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        if (int'(idx) >= N_REQ - 1) return '0;
        return idx + IW'(1);
    endfunction

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req     (bus.req),
        .ptr     (rr_ptr_q),
        .winner  (pick_onehot),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    // While locked only the owner is eligible; any exit from the lock
    // (timeout, lock dropped, req dropped) returns to round-robin.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        lock_cnt_d    = lock_cnt_q;
        lock_broken_d = 1'b0;
        gnt_c         = '0;
        win_idx       = '0;

        if (state_q == ARB_LOCKED) begin
            if (bus.req[owner_q]) begin
                gnt_c[owner_q] = 1'b1;
                win_idx        = owner_q;
                if (bus.lock[owner_q] && (lock_cnt_q < CNT_W'(MAX_LOCK - 1))) begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end else begin
                    state_d       = ARB_FREE;
                    rr_ptr_d      = next_idx(owner_q);
                    lock_cnt_d    = '0;
                    lock_broken_d = bus.lock[owner_q];
                end
            end else begin
                state_d    = ARB_FREE;
                lock_cnt_d = '0;
            end
        end else if (pick_any) begin
            gnt_c    = pick_onehot;
            win_idx  = pick_idx;
            rr_ptr_d = next_idx(pick_idx);
            if (bus.lock[pick_idx]) begin
                if (MAX_LOCK > 1) begin
                    state_d    = ARB_LOCKED;
                    owner_d    = pick_idx;
                    lock_cnt_d = CNT_W'(1);
                end else begin
                    lock_broken_d = 1'b1;
                end
            end
        end

        sel_addr = (|gnt_c) ? bus.req_addr[int'(win_idx)*AW +: AW] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB_FREE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            lock_cnt_q    <= '0;
            rsp_valid_q   <= '0;
            lock_broken_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            lock_cnt_q    <= lock_cnt_d;
            rsp_valid_q   <= gnt_c;
            lock_broken_q <= lock_broken_d;
        end
    end

    assign bus.gnt         = gnt_c;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = bus.mem_rd_data;
    assign bus.lock_broken = lock_broken_q;
    assign bus.mem_rd_slot = sel_addr[ROW_W+COL_W +: SLOT_W];
    assign bus.mem_rd_row  = sel_addr[COL_W +: ROW_W];
    assign bus.mem_rd_col  = sel_addr[0 +: COL_W];

endmodule

// File: tb/tb_mat_rd_arbiter.sv
// Directed bench for mat_rd_arbiter: one instance with the default lock bound
// and one with MAX_LOCK = 4 for the timeout case.
module tb_mat_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  reqDrv;
    logic [2:0]  lockDrv;
    logic [23:0] addrDrv;
    logic        selB;

    always #5 clk = ~clk;

    mat_rd_arbiter_if #(.N_REQ(3), .DW(16), .AW(8)) ifA ();
    mat_rd_arbiter_if #(.N_REQ(3), .DW(16), .AW(8)) ifB ();

    logic [15:0] memDataA;
    logic [15:0] memDataB;

    assign ifA.req         = reqDrv;
    assign ifA.lock        = lockDrv;
    assign ifA.req_addr    = addrDrv;
    assign ifA.mem_rd_data = memDataA;
    assign ifB.req         = reqDrv;
    assign ifB.lock        = lockDrv;
    assign ifB.req_addr    = addrDrv;
    assign ifB.mem_rd_data = memDataB;

    // Memory model: data = D0 followed by the packed address read last cycle
    always @(posedge clk) begin
        memDataA <= {8'hD0, ifA.mem_rd_slot, ifA.mem_rd_row, ifA.mem_rd_col};
        memDataB <= {8'hD0, ifB.mem_rd_slot, ifB.mem_rd_row, ifB.mem_rd_col};
    end

    mat_rd_arbiter #(.N_REQ(3), .DW(16), .AW(8), .MAX_LOCK(16)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifA.slave)
    );

    mat_rd_arbiter #(.N_REQ(3), .DW(16), .AW(8), .MAX_LOCK(4)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifB.slave)
    );

    logic [2:0]  obsGnt;
    logic [2:0]  obsRsp;
    logic [7:0]  obsAddr;
    logic [15:0] obsData;
    logic        obsBroken;

    assign obsGnt    = selB ? ifB.gnt : ifA.gnt;
    assign obsRsp    = selB ? ifB.rsp_valid : ifA.rsp_valid;
    assign obsAddr   = selB ? {ifB.mem_rd_slot, ifB.mem_rd_row, ifB.mem_rd_col}
                            : {ifA.mem_rd_slot, ifA.mem_rd_row, ifA.mem_rd_col};
    assign obsData   = selB ? ifB.rsp_data : ifA.rsp_data;
    assign obsBroken = selB ? ifB.lock_broken : ifA.lock_broken;

    int compareCount = 0;
    int failCount    = 0;
    logic [2:0] prevGnt;
    logic [7:0] prevAddr;

    logic [7:0] kAddr [9] = '{8'h00, 8'h01, 8'h02, 8'h08, 8'h09, 8'h0A, 8'h10, 8'h11, 8'h12};
    logic [7:0] rrAddr [3] = '{8'h11, 8'h22, 8'h33};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic [2:0] l, input logic [23:0] a);
        reqDrv  = r;
        lockDrv = l;
        addrDrv = a;
    endtask

    // One clock cycle: drive, sample mid-cycle, then advance to 1 ns past the edge
    task automatic runCycle(input string tag, input logic [2:0] r, input logic [2:0] l,
                            input logic [23:0] a, input logic [2:0] expGnt,
                            input logic [7:0] expAddr, input logic expBroken);
        applyStimulus(r, l, a);
        #3;
        checkOutput({tag, ".gnt"}, 32'(obsGnt), 32'(expGnt));
        checkOutput({tag, ".addr"}, 32'(obsAddr), 32'(expAddr));
        checkOutput({tag, ".rsp_valid"}, 32'(obsRsp), 32'(prevGnt));
        if (prevGnt != 3'b000)
            checkOutput({tag, ".rsp_data"}, 32'(obsData), 32'({8'hD0, prevAddr}));
        checkOutput({tag, ".lock_broken"}, 32'(obsBroken), 32'(expBroken));
        prevGnt  = expGnt;
        prevAddr = expAddr;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input string tag);
        applyStimulus(3'b000, 3'b000, 24'h0);
        rst_n = 1'b0;
        #3;
        checkOutput({tag, ".rst_gnt"}, 32'(obsGnt), 32'd0);
        checkOutput({tag, ".rst_rsp"}, 32'(obsRsp), 32'd0);
        checkOutput({tag, ".rst_addr"}, 32'(obsAddr), 32'd0);
        checkOutput({tag, ".rst_broken"}, 32'(obsBroken), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n    = 1'b1;
        prevGnt  = 3'b000;
        prevAddr = 8'h00;
    endtask

    initial begin
        rst_n = 1'b0;
        selB  = 1'b0;
        prevGnt  = 3'b000;
        prevAddr = 8'h00;
        applyStimulus(3'b000, 3'b000, 24'h0);
        @(posedge clk);
        #1;

        $display("[TB] single requester");
        doReset("t1");
        for (int i = 0; i < 3; i++)
            runCycle("t1", 3'b001, 3'b000, 24'h00000A, 3'b001, 8'h0A, 1'b0);
        runCycle("t1.idle", 3'b000, 3'b000, 24'h0, 3'b000, 8'h00, 1'b0);
        runCycle("t1.idle", 3'b000, 3'b000, 24'h0, 3'b000, 8'h00, 1'b0);

        $display("[TB] round robin, all requesting");
        doReset("t2");
        for (int i = 0; i < 6; i++)
            runCycle("t2", 3'b111, 3'b000, 24'h332211, 3'(3'b001 << (i % 3)), rrAddr[i % 3], 1'b0);
        runCycle("t2.idle", 3'b000, 3'b000, 24'h0, 3'b000, 8'h00, 1'b0);

        $display("[TB] conv kernel load with lock");
        doReset("t3");
        for (int i = 0; i < 9; i++)
            runCycle("t3.kern", 3'b011, (i < 8) ? 3'b001 : 3'b000, {8'h00, 8'h3F, kAddr[i]},
                     3'b001, kAddr[i], 1'b0);
        runCycle("t3.next", 3'b010, 3'b000, 24'h003F00, 3'b010, 8'h3F, 1'b0);
        runCycle("t3.idle", 3'b000, 3'b000, 24'h0, 3'b000, 8'h00, 1'b0);

        $display("[TB] lock timeout at MAX_LOCK = 4");
        selB = 1'b1;
        doReset("t4");
        runCycle("t4.lock", 3'b100, 3'b100, 24'h2C0005, 3'b100, 8'h2C, 1'b0);
        for (int i = 0; i < 3; i++)
            runCycle("t4.lock", 3'b101, 3'b100, 24'h2C0005, 3'b100, 8'h2C, 1'b0);
        runCycle("t4.break", 3'b101, 3'b100, 24'h2C0005, 3'b001, 8'h05, 1'b1);
        runCycle("t4.relock", 3'b101, 3'b100, 24'h2C0005, 3'b100, 8'h2C, 1'b0);
        runCycle("t4.idle", 3'b000, 3'b000, 24'h0, 3'b000, 8'h00, 1'b0);
        runCycle("t4.idle", 3'b000, 3'b000, 24'h0, 3'b000, 8'h00, 1'b0);
        selB = 1'b0;

        $display("[TB] owner drops req while locked");
        doReset("t5");
        runCycle("t5.lock", 3'b011, 3'b001, 24'h004107, 3'b001, 8'h07, 1'b0);
        runCycle("t5.gap", 3'b010, 3'b000, 24'h004100, 3'b000, 8'h00, 1'b0);
        runCycle("t5.next", 3'b010, 3'b000, 24'h004100, 3'b010, 8'h41, 1'b0);
        runCycle("t5.idle", 3'b000, 3'b000, 24'h0, 3'b000, 8'h00, 1'b0);

        $display("[TB] reset with response outstanding");
        doReset("t6");
        runCycle("t6.a", 3'b111, 3'b000, 24'h332211, 3'b001, 8'h11, 1'b0);
        runCycle("t6.b", 3'b111, 3'b000, 24'h332211, 3'b010, 8'h22, 1'b0);
        checkOutput("t6.pending_rsp", 32'(obsRsp), 32'(3'b010));
        rst_n = 1'b0;
        #1;
        checkOutput("t6.rsp_cleared", 32'(obsRsp), 32'd0);
        applyStimulus(3'b000, 3'b000, 24'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n    = 1'b1;
        prevGnt  = 3'b000;
        prevAddr = 8'h00;
        runCycle("t6.after", 3'b111, 3'b000, 24'h332211, 3'b001, 8'h11, 1'b0);
        runCycle("t6.after", 3'b111, 3'b000, 24'h332211, 3'b010, 8'h22, 1'b0);
        runCycle("t6.idle", 3'b000, 3'b000, 24'h0, 3'b000, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
